// File: rtl/rv32i_core.sv
// Single-cycle RV32I core with internal 1K-word instruction and data memories.
// Fetch, decode, execute, memory and write-back all complete within one clock.

module rv32i_mem (
   input  logic        clk,
   input  logic        we,
   input  logic [9:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);
   logic [31:0] mem [0:1023];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];
endmodule

module rv32i_regfile (
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   input  logic [4:0]  rd_addr,
   input  logic [31:0] rd_data,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data
);
   logic [31:0] regFile [0:31];

   always_ff @(posedge clk) begin
      if (we && rd_addr != 5'd0) regFile[rd_addr] <= rd_data;
   end

   assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regFile[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regFile[rs2_addr];
endmodule

module rv32i_core (
   input logic clk,
   input logic reset
);
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [31:0] NOP      = 32'h00000013;

   logic [31:0] pc, pc_in, pc_plus4;
   logic [31:0] instruction, instruction_mux_out;
   logic [31:0] mux_a_out, mux_b_out, alu_out;
   logic [31:0] rs1_data, rs2_data, wb_data, load_data;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  shamt;
   logic        alt_op, reg_we, is_store, branch_taken;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc <= 32'd0;
      else        pc <= pc_in;
   end

   rv32i_mem insn_memory (
      .clk   (clk),
      .we    (1'b0),
      .addr  (pc[11:2]),
      .wdata (32'd0),
      .rdata (instruction)
   );

   // Holding a NOP during reset keeps rd = x0 and blocks stores without extra gating.
   assign instruction_mux_out = reset ? instruction : NOP;

   assign opcode = instruction_mux_out[6:0];
   assign funct3 = instruction_mux_out[14:12];
   assign alt_op = instruction_mux_out[30];

   assign imm_i = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:20]};
   assign imm_s = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:25],
                   instruction_mux_out[11:7]};
   assign imm_b = {{19{instruction_mux_out[31]}}, instruction_mux_out[31],
                   instruction_mux_out[7], instruction_mux_out[30:25],
                   instruction_mux_out[11:8], 1'b0};
   assign imm_u = {instruction_mux_out[31:12], 12'd0};
   assign imm_j = {{11{instruction_mux_out[31]}}, instruction_mux_out[31],
                   instruction_mux_out[19:12], instruction_mux_out[20],
                   instruction_mux_out[30:21], 1'b0};

   rv32i_regfile register_file (
      .clk      (clk),
      .we       (reg_we),
      .rs1_addr (instruction_mux_out[19:15]),
      .rs2_addr (instruction_mux_out[24:20]),
      .rd_addr  (instruction_mux_out[11:7]),
      .rd_data  (wb_data),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data)
   );

   // Branches use the ALU for the target; the compare is done separately on rs1/rs2.
   always_comb begin
      mux_a_out = rs1_data;
      mux_b_out = imm_i;
      case (opcode)
         OP_R:      mux_b_out = rs2_data;
         OP_STORE:  mux_b_out = imm_s;
         OP_LUI:    begin mux_a_out = 32'd0; mux_b_out = imm_u; end
         OP_AUIPC:  begin mux_a_out = pc;    mux_b_out = imm_u; end
         OP_JAL:    begin mux_a_out = pc;    mux_b_out = imm_j; end
         OP_BRANCH: begin mux_a_out = pc;    mux_b_out = imm_b; end
         default:   ;
      endcase
   end

   assign shamt = mux_b_out[4:0];

   always_comb begin
      alu_out = mux_a_out + mux_b_out;
      if (opcode == OP_R || opcode == OP_IMM) begin
         case (funct3)
            3'b000: if (opcode == OP_R && alt_op) alu_out = mux_a_out - mux_b_out;
            3'b001: alu_out = mux_a_out << shamt;
            3'b010: alu_out = {31'd0, $signed(mux_a_out) < $signed(mux_b_out)};
            3'b011: alu_out = {31'd0, mux_a_out < mux_b_out};
            3'b100: alu_out = mux_a_out ^ mux_b_out;
            3'b101: begin
               if (alt_op) alu_out = $signed(mux_a_out) >>> shamt;
               else        alu_out = mux_a_out >> shamt;
            end
            3'b110: alu_out = mux_a_out | mux_b_out;
            default: alu_out = mux_a_out & mux_b_out;
         endcase
      end
   end

   always_comb begin
      case (funct3)
         3'b000:  branch_taken = (rs1_data == rs2_data);
         3'b001:  branch_taken = (rs1_data != rs2_data);
         3'b100:  branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
         3'b101:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
         3'b110:  branch_taken = (rs1_data <  rs2_data);
         3'b111:  branch_taken = (rs1_data >= rs2_data);
         default: branch_taken = 1'b0;
      endcase
   end

   assign is_store = (opcode == OP_STORE);

   rv32i_mem data_memory (
      .clk   (clk),
      .we    (is_store),
      .addr  (alu_out[11:2]),
      .wdata (rs2_data),
      .rdata (load_data)
   );

   assign reg_we = (opcode == OP_R)   || (opcode == OP_IMM)  || (opcode == OP_LOAD) ||
                   (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_LUI)  ||
                   (opcode == OP_AUIPC);

   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      if (opcode == OP_LOAD)                         wb_data = load_data;
      else if (opcode == OP_JAL || opcode == OP_JALR) wb_data = pc_plus4;
      else                                            wb_data = alu_out;
   end

   always_comb begin
      pc_in = pc_plus4;
      if (opcode == OP_JAL || (opcode == OP_BRANCH && branch_taken)) pc_in = alu_out;
      if (opcode == OP_JALR) pc_in = {alu_out[31:1], 1'b0};
   end
endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: single-instruction vector table followed by
// multi-cycle program, memory, branch and reset sequences.

module tb_rv32i_core;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   rv32i_core dut (
      .clk   (clk),
      .reset (reset)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] insn;
      logic [31:0] a;       // x1
      logic [31:0] b;       // x2
      logic [31:0] exp_x3;
      logic [31:0] exp_pc_in;
   } vec_t;

   localparam int NV = 30;
   localparam logic [31:0] SENT = 32'hDEADBEEF;
   vec_t vecs [NV];

   // RV32I encoders: rd = x3, rs1 = x1, rs2 = x2 unless stated.
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
      return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [6:0] op);
      return {imm, 5'd1, f3, 5'd3, op};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [2:0] f3);
      return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] off);
      return {off[20], off[10:1], off[11], off[19:12], 5'd3, 7'b1101111};
   endfunction
   function automatic vec_t mk(input logic [31:0] insn, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] x3,
                               input logic [31:0] pcn);
      vec_t v;
      v.insn = insn; v.a = a; v.b = b; v.exp_x3 = x3; v.exp_pc_in = pcn;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 1024; i++) dut.insn_memory.mem[i] = 32'd0;
   endtask

   task automatic load_base_program();
      clear_imem();
      for (int k = 0; k < 32; k++) dut.register_file.regFile[k] = k;
      dut.insn_memory.mem[0] = 32'h03208093;   // ADDI x1,x1,50
      dut.insn_memory.mem[1] = 32'h01410113;   // ADDI x2,x2,20
      dut.insn_memory.mem[2] = 32'h002081B3;   // ADD  x3,x1,x2
   endtask

   initial begin
      vecs[0]  = mk(enc_r(7'h00, 3'b000), 32'd5, 32'd7, 32'd12, 32'd4);              // ADD
      vecs[1]  = mk(enc_r(7'h20, 3'b000), 32'd5, 32'd7, 32'hFFFFFFFE, 32'd4);        // SUB
      vecs[2]  = mk(enc_r(7'h00, 3'b001), 32'd1, 32'h24, 32'd16, 32'd4);             // SLL
      vecs[3]  = mk(enc_r(7'h00, 3'b010), 32'hFFFFFFFF, 32'd1, 32'd1, 32'd4);        // SLT
      vecs[4]  = mk(enc_r(7'h00, 3'b011), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd4);        // SLTU
      vecs[5]  = mk(enc_r(7'h00, 3'b100), 32'hF0F0, 32'h0FF0, 32'hFF00, 32'd4);      // XOR
      vecs[6]  = mk(enc_r(7'h00, 3'b101), 32'h80000000, 32'd4, 32'h08000000, 32'd4); // SRL
      vecs[7]  = mk(enc_r(7'h20, 3'b101), 32'h80000000, 32'd4, 32'hF8000000, 32'd4); // SRA
      vecs[8]  = mk(enc_r(7'h00, 3'b110), 32'hF0, 32'h0F, 32'hFF, 32'd4);            // OR
      vecs[9]  = mk(enc_r(7'h00, 3'b111), 32'hF0, 32'h3C, 32'h30, 32'd4);            // AND
      vecs[10] = mk(enc_i(12'hFFF, 3'b000, 7'h13), 32'd10, 32'd0, 32'd9, 32'd4);     // ADDI -1
      vecs[11] = mk(enc_i(12'd5, 3'b010, 7'h13), 32'hFFFFFFFD, 32'd0, 32'd1, 32'd4); // SLTI
      vecs[12] = mk(enc_i(12'hFFF, 3'b011, 7'h13), 32'd5, 32'd0, 32'd1, 32'd4);      // SLTIU
      vecs[13] = mk(enc_i(12'h0FF, 3'b100, 7'h13), 32'h0F, 32'd0, 32'hF0, 32'd4);    // XORI
      vecs[14] = mk(enc_i(12'hFF0, 3'b110, 7'h13), 32'd3, 32'd0, 32'hFFFFFFF3, 32'd4); // ORI
      vecs[15] = mk(enc_i(12'h07F, 3'b111, 7'h13), 32'h1234, 32'd0, 32'h34, 32'd4);  // ANDI
      vecs[16] = mk(enc_i(12'd3, 3'b001, 7'h13), 32'd3, 32'd0, 32'd24, 32'd4);       // SLLI
      vecs[17] = mk(enc_i(12'h01F, 3'b101, 7'h13), 32'h80000000, 32'd0, 32'd1, 32'd4); // SRLI
      vecs[18] = mk(enc_i(12'h41F, 3'b101, 7'h13), 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd4); // SRAI
      vecs[19] = mk({20'h12345, 5'd3, 7'b0110111}, 32'd0, 32'd0, 32'h12345000, 32'd4); // LUI
      vecs[20] = mk({20'h00001, 5'd3, 7'b0010111}, 32'd0, 32'd0, 32'h00001000, 32'd4); // AUIPC
      vecs[21] = mk(enc_j(21'h100), 32'd0, 32'd0, 32'd4, 32'h100);                   // JAL
      vecs[22] = mk(enc_i(12'd5, 3'b000, 7'h67), 32'h200, 32'd0, 32'd4, 32'h204);    // JALR
      vecs[23] = mk(enc_b(13'd16, 5'd1, 5'd2, 3'b000), 32'd7, 32'd7, SENT, 32'd16);  // BEQ
      vecs[24] = mk(enc_b(13'd16, 5'd1, 5'd2, 3'b001), 32'd7, 32'd7, SENT, 32'd4);   // BNE
      vecs[25] = mk(enc_b(13'd16, 5'd1, 5'd2, 3'b100), 32'hFFFFFFFF, 32'd1, SENT, 32'd16); // BLT
      vecs[26] = mk(enc_b(13'd16, 5'd1, 5'd2, 3'b101), 32'hFFFFFFFF, 32'd1, SENT, 32'd4);  // BGE
      vecs[27] = mk(enc_b(13'd16, 5'd1, 5'd2, 3'b110), 32'hFFFFFFFF, 32'd1, SENT, 32'd4);  // BLTU
      vecs[28] = mk(enc_b(13'd16, 5'd1, 5'd2, 3'b111), 32'hFFFFFFFF, 32'd1, SENT, 32'd16); // BGEU
      vecs[29] = mk(32'd0, 32'd1, 32'd2, SENT, 32'd4);                                // unknown

      clear_imem();
      #1;
      check("reset_pc", dut.pc, 32'd0);
      check("reset_insn_nop", dut.instruction_mux_out, 32'h00000013);

      // Each vector runs from pc = 0 for exactly one edge.
      for (int v = 0; v < NV; v++) begin
         @(negedge clk);
         reset = 1'b0;
         dut.insn_memory.mem[0] = vecs[v].insn;
         dut.register_file.regFile[1] = vecs[v].a;
         dut.register_file.regFile[2] = vecs[v].b;
         dut.register_file.regFile[3] = SENT;
         #1 reset = 1'b1;
         #1;
         check($sformatf("vec%0d_pc_in", v), dut.pc_in, vecs[v].exp_pc_in);
         tick();
         check($sformatf("vec%0d_x3", v), dut.register_file.regFile[3], vecs[v].exp_x3);
         $display("vec %0d insn %08h x3 %08h pc %08h", v, vecs[v].insn,
                  dut.register_file.regFile[3], dut.pc);
      end

      // Base program, then zero words acting as no-ops.
      load_base_program();
      pulse_reset();
      tick(); check("prog_x1", dut.register_file.regFile[1], 32'd51);
      tick(); check("prog_x2", dut.register_file.regFile[2], 32'd22);
      tick(); check("prog_x3", dut.register_file.regFile[3], 32'd73);
      check("prog_pc", dut.pc, 32'd12);
      tick(); tick();
      check("nop_pc", dut.pc, 32'd20);
      check("nop_x1", dut.register_file.regFile[1], 32'd51);
      check("nop_x3", dut.register_file.regFile[3], 32'd73);
      $display("program pc %08h x3 %08h", dut.pc, dut.register_file.regFile[3]);

      // Writes to x0 are discarded.
      clear_imem();
      dut.register_file.regFile[0] = 32'd0;
      dut.insn_memory.mem[0] = 32'h00500013;   // ADDI x0,x0,5
      pulse_reset();
      tick();
      check("x0_zero", dut.register_file.regFile[0], 32'd0);
      $display("x0 write pc %08h x0 %08h", dut.pc, dut.register_file.regFile[0]);

      // Store then load through the same word.
      clear_imem();
      dut.register_file.regFile[3] = 32'd73;
      dut.register_file.regFile[4] = 32'd0;
      dut.data_memory.mem[2] = 32'd0;
      dut.insn_memory.mem[0] = 32'h00302423;   // SW x3,8(x0)
      dut.insn_memory.mem[1] = 32'h00802203;   // LW x4,8(x0)
      pulse_reset();
      tick(); check("sw_mem2", dut.data_memory.mem[2], 32'd73);
      tick(); check("lw_x4", dut.register_file.regFile[4], 32'd73);
      $display("sw/lw mem2 %08h x4 %08h", dut.data_memory.mem[2], dut.register_file.regFile[4]);

      // Backward branch at pc = 16.
      clear_imem();
      dut.register_file.regFile[1] = 32'd9;
      dut.insn_memory.mem[4] = enc_b(-13'sd8, 5'd1, 5'd1, 3'b000);   // BEQ x1,x1,-8
      pulse_reset();
      tick(); tick(); tick(); tick();
      check("br_pc16", dut.pc, 32'd16);
      check("beq_back", dut.pc_in, 32'd8);
      dut.insn_memory.mem[4] = enc_b(-13'sd8, 5'd1, 5'd1, 3'b001);   // BNE x1,x1,-8
      #1;
      check("bne_equal", dut.pc_in, 32'd20);
      $display("branch pc %08h pc_in %08h", dut.pc, dut.pc_in);

      // Asynchronous reset in mid-run, state retention and restart.
      load_base_program();
      pulse_reset();
      tick(); tick();
      check("mid_pc8", dut.pc, 32'd8);
      #2 reset = 1'b0;
      #1;
      check("async_pc0", dut.pc, 32'd0);
      check("keep_x1", dut.register_file.regFile[1], 32'd51);
      check("keep_x2", dut.register_file.regFile[2], 32'd22);
      tick(); tick();
      check("held_pc0", dut.pc, 32'd0);
      check("held_x3", dut.register_file.regFile[3], 32'd3);
      @(negedge clk);
      #1 reset = 1'b1;
      tick();
      check("restart_x1", dut.register_file.regFile[1], 32'd101);
      check("restart_pc", dut.pc, 32'd4);
      $display("restart pc %08h x1 %08h", dut.pc, dut.register_file.regFile[1]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
